// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches NUM_SRC lines into pending bits, masks them, requests the CPU.
// Latency: bus reads are combinational (read-old); pending/int_req update one clock after the causing event.
// Backpressure: none, every bus access completes in its cycle; the bus is never stalled.
module int_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [31:0]        bus_addr,
  input  logic               bus_we,
  input  logic [3:0]         bus_byteen,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_sel,
  output logic               int_req
);

  localparam logic [1:0] OFF_MODE = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_PEND = 2'd2;

  logic [NUM_SRC-1:0] mode_q, mask_q, pend_q, src_d;
  logic [NUM_SRC-1:0] mode_n, mask_n, pend_n;
  logic [NUM_SRC-1:0] set_v, clr_v, active, lane_bits, wbits;
  logic [31:0]        lane_mask, wdata_m, id;
  logic [1:0]         off;
  logic               wr_en;
  logic               unused_bits;

  assign bus_sel   = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = bus_addr[3:2];
  assign wr_en     = bus_sel & bus_we & (|bus_byteen);
  assign lane_mask = {{8{bus_byteen[3]}}, {8{bus_byteen[2]}},
                      {8{bus_byteen[1]}}, {8{bus_byteen[0]}}};
  assign wdata_m   = bus_wdata & lane_mask;
  assign lane_bits = lane_mask[NUM_SRC-1:0];
  assign wbits     = wdata_m[NUM_SRC-1:0];
  assign active    = pend_q & mask_q;

  // Address byte offset and data bits above NUM_SRC carry no meaning here.
  assign unused_bits = &{1'b0, bus_addr[1:0], wdata_m};

  // Next-state for the register file: lane-merged writes, W1C clears, set-wins pending update.
  always_comb begin
    mode_n = mode_q;
    mask_n = mask_q;
    clr_v  = '0;
    if (wr_en) begin
      case (off)
        OFF_MODE: mode_n = (mode_q & ~lane_bits) | wbits;
        OFF_MASK: mask_n = (mask_q & ~lane_bits) | wbits;
        OFF_PEND: clr_v  = wbits;
        default:  ;
      endcase
    end
    // Edge sources pend on a 0->1 transition only; level sources pend while high.
    set_v  = (mode_q & src & ~src_d) | (~mode_q & src);
    pend_n = set_v | (pend_q & ~clr_v);
  end

  // Lowest-numbered active source wins; all-ones means nothing is pending and enabled.
  always_comb begin
    id = '1;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) id = $unsigned(i);
    end
  end

  // Read mux shows state before any same-cycle write; zero outside the window.
  always_comb begin
    bus_rdata = '0;
    if (bus_sel) begin
      case (off)
        OFF_MODE: bus_rdata[NUM_SRC-1:0] = mode_q;
        OFF_MASK: bus_rdata[NUM_SRC-1:0] = mask_q;
        OFF_PEND: bus_rdata[NUM_SRC-1:0] = pend_q;
        default:  bus_rdata = id;
      endcase
    end
  end

  // Register state and the registered request, computed from next-state so it lags events by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      src_d   <= '0;
      int_req <= 1'b0;
    end else begin
      mode_q  <= mode_n;
      mask_q  <= mask_n;
      pend_q  <= pend_n;
      src_d   <= src;
      int_req <= |(pend_n & mask_n);
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic against a reference model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled before the next posedge.
// Backpressure: not applicable; the DUT never stalls the bus.
module tb_int_ctrl;
  localparam logic [31:0] BASE = 32'h0000_7F40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_sel;
  logic        int_req;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] m_mode = '0, m_mask = '0, m_pend = '0, m_srcd = '0;
  logic       m_req = 1'b0;

  always #5 clk = ~clk;

  int_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_sel(bus_sel), .int_req(int_req)
  );

  function automatic logic [31:0] model_id();
    for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) return 32'(i);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return {24'h0, m_mode};
      2'd1:    return {24'h0, m_mask};
      2'd2:    return {24'h0, m_pend};
      default: return model_id();
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [7:0] np, nmode, nmask;
    logic       wr, lane_on, set_b, clr_b;
    if (reset) begin
      m_mode = '0; m_mask = '0; m_pend = '0; m_srcd = '0; m_req = 1'b0;
    end else begin
      wr = (bus_addr[31:4] == BASE[31:4]) && bus_we && (bus_byteen != 4'h0);
      nmode = m_mode;
      nmask = m_mask;
      for (int i = 0; i < 8; i++) begin
        lane_on = bus_byteen[i / 8];
        set_b = m_mode[i] ? (src[i] && !m_srcd[i]) : src[i];
        clr_b = wr && (bus_addr[3:2] == 2'd2) && lane_on && bus_wdata[i];
        np[i] = set_b || (m_pend[i] && !clr_b);
        if (wr && lane_on && bus_addr[3:2] == 2'd0) nmode[i] = bus_wdata[i];
        if (wr && lane_on && bus_addr[3:2] == 2'd1) nmask[i] = bus_wdata[i];
      end
      m_pend = np; m_mode = nmode; m_mask = nmask; m_srcd = src;
      m_req = |(np & nmask);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_addr = a; bus_we = 1'b1; bus_byteen = be; bus_wdata = d;
    tick();
    bus_we = 1'b0; bus_byteen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a; bus_we = 1'b0;
    #1;
    d = bus_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; src = 8'hFF; bus_addr = BASE; bus_we = 1'b0; bus_byteen = 4'h0; bus_wdata = '0;
    repeat (3) tick();
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_pend_hold got=%h exp=%h", d, 32'h0); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req_hold got=%b exp=0", int_req); end
    reset = 1'b0; src = 8'h00;
    tick();
    rd(BASE + 32'h0, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mode got=%h exp=%h", d, 32'h0); end
    rd(BASE + 32'h4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=%h", d, 32'h0); end
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h exp=%h", d, 32'h0); end
    rd(BASE + 32'hC, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_id got=%h exp=ffffffff", d); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", int_req); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    wr(BASE + 32'h0, 32'h4, 4'h1);
    wr(BASE + 32'h4, 32'h4, 4'h1);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL edge_req_before got=%b exp=0", int_req); end
    src = 8'h04; tick(); src = 8'h00;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL edge_req got=%b exp=1", int_req); end
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL edge_pend got=%h exp=%h", d, 32'h4); end
    rd(BASE + 32'hC, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL edge_id got=%h exp=%h", d, 32'h2); end
    wr(BASE + 32'h8, 32'h4, 4'h1);
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_clear got=%h exp=%h", d, 32'h0); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL edge_req_clear got=%b exp=0", int_req); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    wr(BASE + 32'h0, 32'h0, 4'hF);
    wr(BASE + 32'h4, 32'h1, 4'hF);
    src = 8'h01; tick();
    wr(BASE + 32'h8, 32'h1, 4'h1);
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL level_repend got=%h exp=%h", d, 32'h1); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL level_req got=%b exp=1", int_req); end
    src = 8'h00;
    wr(BASE + 32'h8, 32'h1, 4'h1);
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL level_clear got=%h exp=%h", d, 32'h0); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL level_req_clear got=%b exp=0", int_req); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr(BASE + 32'h4, 32'h20, 4'h1);
    src = 8'h28; tick(); src = 8'h00; tick();
    rd(BASE + 32'hC, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL prio_id5 got=%h exp=%h", d, 32'h5); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_req got=%b exp=1", int_req); end
    wr(BASE + 32'h4, 32'h28, 4'h1);
    rd(BASE + 32'hC, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL prio_id3 got=%h exp=%h", d, 32'h3); end
    wr(BASE + 32'h4, 32'h0, 4'h1);
    rd(BASE + 32'hC, d);
    total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL prio_id_none got=%h exp=ffffffff", d); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL prio_req_masked got=%b exp=0", int_req); end
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h28) begin bad++; $display("FAIL prio_pend_masked got=%h exp=%h", d, 32'h28); end
    wr(BASE + 32'h8, 32'hFF, 4'h1);
  endtask

  task automatic test_simul();
    logic [31:0] d;
    wr(BASE + 32'h0, 32'h2, 4'h1);
    wr(BASE + 32'h4, 32'h2, 4'h1);
    src = 8'h02; tick(); src = 8'h00; tick();
    src = 8'h02;
    wr(BASE + 32'h8, 32'h2, 4'h1);
    src = 8'h00;
    rd(BASE + 32'h8, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL simul_set_wins got=%h exp=%h", d, 32'h2); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL simul_req got=%b exp=1", int_req); end
    wr(BASE + 32'h8, 32'hFF, 4'h1);
  endtask

  task automatic test_byteen();
    logic [31:0] d;
    wr(BASE + 32'h4, 32'h81, 4'h1);
    wr(BASE + 32'h4, 32'hFFFF_FF5A, 4'b0010);
    rd(BASE + 32'h4, d);
    total++; if (d !== 32'h81) begin bad++; $display("FAIL be_lane1_only got=%h exp=%h", d, 32'h81); end
    wr(BASE + 32'h4, 32'hFFFF_FF5A, 4'b0001);
    rd(BASE + 32'h4, d);
    total++; if (d !== 32'h5A) begin bad++; $display("FAIL be_lane0 got=%h exp=%h", d, 32'h5A); end
    bus_addr = BASE + 32'h10; bus_we = 1'b1; bus_byteen = 4'hF; bus_wdata = 32'h0;
    #1;
    total++; if (bus_sel !== 1'b0) begin bad++; $display("FAIL outside_sel got=%b exp=0", bus_sel); end
    total++; if (bus_rdata !== 32'h0) begin bad++; $display("FAIL outside_rdata got=%h exp=%h", bus_rdata, 32'h0); end
    tick();
    bus_we = 1'b0; bus_byteen = 4'h0;
    rd(BASE + 32'h7, d);
    total++; if (d !== 32'h5A) begin bad++; $display("FAIL outside_mask_kept got=%h exp=%h", d, 32'h5A); end
    rd(BASE + 32'h0, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL outside_mode_kept got=%h exp=%h", d, 32'h2); end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 600; n++) begin
      src = 8'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 9);
      if (r < 8) bus_addr = BASE + 32'(r % 4) * 32'h4 + 32'($urandom_range(0, 3));
      else       bus_addr = BASE + 32'h10 * 32'($urandom_range(1, 4));
      bus_we     = 1'($urandom_range(0, 1));
      bus_byteen = 4'($urandom);
      bus_wdata  = $urandom;
      #1;
      total++; if (bus_sel !== (bus_addr[31:4] == BASE[31:4])) begin bad++; $display("FAIL rnd_sel n=%0d got=%b", n, bus_sel); end
      total++; if (bus_rdata !== model_rdata(bus_addr)) begin bad++; $display("FAIL rnd_rdata n=%0d addr=%h got=%h exp=%h", n, bus_addr, bus_rdata, model_rdata(bus_addr)); end
      total++; if (int_req !== m_req) begin bad++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, int_req, m_req); end
      tick();
    end
    bus_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_simul();
    test_byteen();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
